ssm_modmul_param: RTL and testbench

SSM_MODMUL_PARAM -- requirements
Module: ssm_modmul_param

---
 rtl/ssm_modmul_param_if.sv | 14 +
 rtl/ssm_modmul_param.sv | 161 ++++++++++++++++
 tb/tb_ssm_modmul_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ssm_modmul_param_if.sv
// Request/result bundle for the modular multiplier: operands in, status and product out.
interface ssm_modmul_param_if #(parameter int W = 16);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] p;

  modport master (output start, a, b, n, input ready, busy, done, p);
  modport slave  (input start, a, b, n, output ready, busy, done, p);
endinterface

// File: rtl/ssm_modmul_param.sv
// Radix-2 right-to-left interleaved modular multiplier, p = (a*b) mod n.
// Optional macro SSM_MODMUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | ready, waiting for start
// ADD   | P += A when current multiplier bit is set
// RED_P | reduce P below N
// SHA   | A doubles
// RED_A | reduce A below N, advance multiplier bit and counter
// DONE  | result presented on p, one-cycle done
module ssm_modmul_param #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  ssm_modmul_param_if.slave bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    RED_P = 3'd2,
    SHA   = 3'd3,
    RED_A = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // A and P carry one extra bit so P+A and 2A never wrap before reduction
  logic [W:0]    a_q;
  logic [W:0]    p_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  n_q;
  logic [W-1:0]  p_out;
  logic [CW-1:0] cnt;

  logic [W:0]    n_ext;
  logic [W-1:0]  b_shr;
  logic          last_iter;
  logic          n_trivial;
  logic          ready_c;
  logic          busy_c;
  logic          done_c;

  assign n_ext     = {1'b0, n_q};
  assign b_shr     = b_q >> 1;
  assign n_trivial = (n_q[W-1:1] == '0);

  always_comb begin
    last_iter = (cnt == CW'(W - 1));
`ifdef SSM_MODMUL_EARLY_EXIT_EN
    if (b_shr == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy_c    = 1'b1;
        state_nxt = RED_P;
      end
      RED_P: begin
        busy_c    = 1'b1;
        state_nxt = SHA;
      end
      SHA: begin
        busy_c    = 1'b1;
        state_nxt = RED_A;
      end
      RED_A: begin
        busy_c    = 1'b1;
        state_nxt = last_iter ? DONE : ADD;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      p_q   <= '0;
      cnt   <= '0;
      p_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= {1'b0, bus.a};
            b_q <= bus.b;
            n_q <= bus.n;
            p_q <= '0;
            cnt <= '0;
          end
        end
        ADD: begin
          if (b_q[0]) begin
            p_q <= p_q + a_q;
          end
        end
        RED_P: begin
          if (p_q >= n_ext) begin
            p_q <= p_q - n_ext;
          end
        end
        SHA: begin
          a_q <= {a_q[W-1:0], 1'b0};
        end
        RED_A: begin
          if (a_q >= n_ext) begin
            a_q <= a_q - n_ext;
          end
          b_q <= b_shr;
          cnt <= cnt + 1'b1;
          // latch the result on the way into DONE so p is valid alongside done
          if (last_iter) begin
            p_out <= n_trivial ? '0 : p_q[W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.p     = p_out;

endmodule

// File: tb/tb_ssm_modmul_param.sv
// Self-checking bench for ssm_modmul_param: directed and random operations against an arithmetic model.
module tb_ssm_modmul_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ssm_modmul_param_if #(.W(8))  b8  ();
  ssm_modmul_param_if #(.W(16)) b16 ();

  ssm_modmul_param #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  ssm_modmul_param #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  function automatic longint model_p(longint a, longint b, longint n);
    if (n <= 1) return 0;
    return (a * b) % n;
  endfunction

  function automatic int model_lat(int w, longint b);
`ifdef SSM_MODMUL_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < w; i++) if ((b >> i) & 1) k = i + 1;
    return 4 * k + 1;
`else
    return 4 * w + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one W=8 operation; start is re-raised for one cycle at cycles pulse1/pulse2 (0 = never)
  task automatic run8(input int a, input int b, input int n, input int pulse1, input int pulse2,
                      input string tag);
    logic [7:0] p_before;
    int c;
    bit pchg;
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'(a); b8.b = 8'(b); b8.n = 8'(n);
    p_before = b8.p;
    c = 0;
    pchg = 1'b0;
    do begin
      @(posedge clk); #1;
      c++;
      b8.start = (c == pulse1) || (c == pulse2);
      if (c == 1) begin
        check({tag, "_busy"}, 32'(b8.busy), 32'd1);
        check({tag, "_ready"}, 32'(b8.ready), 32'd0);
        b8.a = 8'($urandom); b8.b = 8'($urandom); b8.n = 8'($urandom);
      end
      if (!b8.done && b8.p !== p_before) pchg = 1'b1;
    end while (!b8.done && c < 300);
    b8.start = 1'b0;
    check({tag, "_lat"}, 32'(c), 32'(model_lat(8, b)));
    check({tag, "_p"}, 32'(b8.p), 32'(model_p(a, b, n)));
    check({tag, "_pstable"}, 32'(pchg), 32'd0);
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(b8.ready), 32'd1);
  endtask

  initial begin
    int c, nd, ra, rb, rn;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.n = '0;
    b16.start = 1'b0; b16.a = '0; b16.b = '0; b16.n = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(b8.ready), 32'd1);
    check("rst_busy", 32'(b8.busy), 32'd0);
    check("rst_done", 32'(b8.done), 32'd0);
    check("rst_p", 32'(b8.p), 32'd0);
    @(negedge clk) rst = 1'b0;

    run8(7, 9, 13, 0, 0, "ex_7x9");
    run8(12, 12, 13, 0, 0, "ex_12x12");
    run8(5, 0, 13, 0, 0, "b_zero");
    run8(200, 255, 251, 0, 0, "b_full");
    run8(9, 200, 0, 0, 0, "n_zero");
    run8(3, 7, 1, 0, 0, "n_one");
    run8(100, 130, 211, 3, 20, "ignore_start");

    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (b8.done) nd++; end
    check("ignore_start_nodone", 32'(nd), 32'd0);

    // abort by reset mid-operation
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'd10; b8.b = 8'd11; b8.n = 8'd17;
    c = 0;
    do begin @(posedge clk); #1; c++; b8.start = 1'b0; end while (c < 10);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(b8.ready), 32'd1);
    check("abort_busy", 32'(b8.busy), 32'd0);
    check("abort_p", 32'(b8.p), 32'd0);
    check("abort_done", 32'(b8.done), 32'd0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (50) begin @(posedge clk); #1; if (b8.done) nd++; end
    check("abort_nodone", 32'(nd), 32'd0);
    run8(3, 4, 13, 0, 0, "after_abort");

    // start held high: back-to-back operations
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'd2; b8.b = 8'd3; b8.n = 8'd7;
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!b8.done && c < 300);
    check("hold_first_lat", 32'(c), 32'(model_lat(8, 3)));
    check("hold_first_p", 32'(b8.p), 32'd6);
    repeat (2) begin
      c = 0;
      do begin @(posedge clk); #1; c++; end while (!b8.done && c < 300);
      check("hold_period", 32'(c), 32'(model_lat(8, 3) + 1));
      check("hold_p", 32'(b8.p), 32'd6);
    end
    b8.start = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      rn = $urandom_range(255, 2);
      ra = $urandom_range(rn - 1, 0);
      rb = $urandom_range(rn - 1, 0);
      run8(ra, rb, rn, 0, 0, $sformatf("rnd%0d", i));
    end

    // W=16 boundary case
    @(negedge clk);
    b16.start = 1'b1; b16.a = 16'd65520; b16.b = 16'd65520; b16.n = 16'd65521;
    c = 0;
    do begin @(posedge clk); #1; c++; b16.start = 1'b0; end while (!b16.done && c < 300);
    check("w16_lat", 32'(c), 32'(model_lat(16, 65520)));
    check("w16_p", 32'(b16.p), 32'(model_p(65520, 65520, 65521)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
